// File: rtl/ro_puf_controller.sv
// Sequencer for a serialized ring-oscillator PUF: loads the challenge into the
// scrambler, runs one oscillator race per response bit and assembles the response.
module ro_puf_controller #(
  parameter int RESP_W        = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int EVAL_CYCLES   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        chall_in,
  input  logic              arb_done,
  input  logic              arb_winner,
  output logic              ro_en,
  output logic              dp_clr,
  output logic              scr_load,
  output logic              scr_step,
  output logic [7:0]        chall_out,
  output logic              busy,
  output logic              ready,
  output logic [RESP_W-1:0] response,
  output logic              err
);

  localparam int IDX_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam int ST_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int WD_W  = $clog2(EVAL_CYCLES);

  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_W - 1);
  localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST     = WD_W'(EVAL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_SETTLE,
    S_RACE,
    S_STEP,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_bitIdx;
  logic [ST_W-1:0]     r_settleCnt;
  logic [WD_W-1:0]     r_watchdog;
  logic [RESP_W-1:0]   r_shift;
  logic [RESP_W-1:0]   r_response;
  logic [7:0]          r_chall;
  logic                r_roEn;
  logic                r_dpClr;
  logic                r_scrLoad;
  logic                r_scrStep;
  logic                r_busy;
  logic                r_ready;
  logic                r_err;

  // Outputs are registered for the state being entered, so each strobe is
  // visible exactly during the cycle its state is active.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_bitIdx    <= '0;
      r_settleCnt <= '0;
      r_watchdog  <= '0;
      r_shift     <= '0;
      r_response  <= '0;
      r_chall     <= '0;
      r_roEn      <= 1'b0;
      r_dpClr     <= 1'b0;
      r_scrLoad   <= 1'b0;
      r_scrStep   <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_scrLoad <= 1'b0;
      r_scrStep <= 1'b0;
      r_dpClr   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_LOAD;
            r_chall   <= chall_in;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_shift   <= '0;
            r_bitIdx  <= '0;
            r_scrLoad <= 1'b1;
            r_busy    <= 1'b1;
          end
        end

        S_LOAD: begin
          r_state <= S_CLEAR;
          r_dpClr <= 1'b1;
          r_roEn  <= 1'b0;
        end

        S_CLEAR: begin
          r_state     <= S_SETTLE;
          r_roEn      <= 1'b1;
          r_settleCnt <= '0;
        end

        S_SETTLE: begin
          if (r_settleCnt == SETTLE_LAST) begin
            r_state    <= S_RACE;
            r_watchdog <= '0;
          end else begin
            r_settleCnt <= r_settleCnt + 1'b1;
          end
        end

        // A verdict on the watchdog's last cycle still counts as a clean race.
        S_RACE: begin
          if (arb_done) begin
            r_shift[r_bitIdx] <= arb_winner;
            r_state           <= S_STEP;
            r_roEn            <= 1'b0;
            r_scrStep         <= 1'b1;
          end else if (r_watchdog == WD_LAST) begin
            r_shift[r_bitIdx] <= 1'b0;
            r_err             <= 1'b1;
            r_state           <= S_STEP;
            r_roEn            <= 1'b0;
            r_scrStep         <= 1'b1;
          end else begin
            r_watchdog <= r_watchdog + 1'b1;
          end
        end

        S_STEP: begin
          if (r_bitIdx == IDX_LAST) begin
            r_state    <= S_DONE;
            r_response <= r_shift;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_bitIdx <= r_bitIdx + 1'b1;
            r_state  <= S_CLEAR;
            r_dpClr  <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_roEn  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ro_en     = r_roEn;
  assign dp_clr    = r_dpClr;
  assign scr_load  = r_scrLoad;
  assign scr_step  = r_scrStep;
  assign chall_out = r_chall;
  assign busy      = r_busy;
  assign ready     = r_ready;
  assign response  = r_response;
  assign err       = r_err;

endmodule

// File: tb/tb_ro_puf_controller.sv
// Directed bench for ro_puf_controller: a reactive arbiter model answers each
// race from a per-vector table; results are compared with hand-computed values.
module tb_ro_puf_controller;

  localparam int SETTLE = 4;
  localparam int EVAL   = 1024;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] chall_in;
  logic       arb_done;
  logic       arb_winner;
  logic       ro_en;
  logic       dp_clr;
  logic       scr_load;
  logic       scr_step;
  logic [7:0] chall_out;
  logic       busy;
  logic       ready;
  logic [7:0] response;
  logic       err;

  ro_puf_controller #(
    .RESP_W(8),
    .SETTLE_CYCLES(SETTLE),
    .EVAL_CYCLES(EVAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .chall_in(chall_in),
    .arb_done(arb_done),
    .arb_winner(arb_winner),
    .ro_en(ro_en),
    .dp_clr(dp_clr),
    .scr_load(scr_load),
    .scr_step(scr_step),
    .chall_out(chall_out),
    .busy(busy),
    .ready(ready),
    .response(response),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // arbCyc: RACE cycle (1-based) on which arb_done is raised, 0 = never
  typedef struct {
    logic [7:0] chall;
    int         arbCyc;
    int         toRace;
    int         simRace;
    logic [7:0] winners;
    bit         holdMode;
    int         midStart;
    logic [7:0] expResp;
    bit         expErr;
    int         expLat;
  } vec_t;

  vec_t vecs[7];

  int   passCnt = 0;
  int   totalCnt = 0;
  int   arbCycArr[8];
  logic winArr[8];
  bit   holdMode = 1'b0;
  int   raceIdx = -1;
  int   roCnt = 0;
  int   raceRel;
  int   loadCnt = 0;
  int   stepCnt = 0;
  int   clrCnt = 0;
  int   exclViol = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCnt++;
    if (actual === expected) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Arbiter model and strobe monitor, both evaluated mid-cycle
  always @(negedge clk) begin
    if (scr_load) loadCnt++;
    if (scr_step) stepCnt++;
    if (dp_clr) clrCnt++;
    if ((int'(scr_load) + int'(scr_step) + int'(dp_clr)) > 1 || (ro_en && dp_clr)) exclViol++;
    if (dp_clr) begin
      raceIdx++;
      roCnt = 0;
      arb_done = 1'b0;
      arb_winner = 1'b0;
    end else if (ro_en && raceIdx >= 0 && raceIdx < 8) begin
      roCnt++;
      raceRel = roCnt - SETTLE;
      if (holdMode) begin
        arb_done = 1'b1;
        arb_winner = (raceRel >= 1);
      end else if (raceRel >= 1 && arbCycArr[raceIdx] != 0 && raceRel == arbCycArr[raceIdx]) begin
        arb_done = 1'b1;
        arb_winner = winArr[raceIdx];
      end else begin
        arb_done = 1'b0;
        arb_winner = 1'b0;
      end
    end else begin
      arb_done = 1'b0;
      arb_winner = 1'b0;
    end
  end

  task automatic applyStimulus(input int idx);
    vec_t       v;
    int         cycles;
    int         unstable;
    logic [7:0] prevResp;
    v = vecs[idx];
    for (int i = 0; i < 8; i++) begin
      arbCycArr[i] = (i == v.toRace) ? 0 : (i == v.simRace) ? EVAL : v.arbCyc;
      winArr[i] = v.winners[i];
    end
    holdMode = v.holdMode;
    raceIdx = -1;
    loadCnt = 0;
    stepCnt = 0;
    clrCnt = 0;
    prevResp = response;
    unstable = 0;
    @(negedge clk);
    chall_in = v.chall;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput($sformatf("v%0d busyAfterAccept", idx), 32'(busy), 32'd1);
    checkOutput($sformatf("v%0d loadAfterAccept", idx), 32'(scr_load), 32'd1);
    checkOutput($sformatf("v%0d readyCleared", idx), 32'(ready), 32'd0);
    cycles = 1;
    while (!ready && cycles < 20000) begin
      if (response !== prevResp) unstable++;
      if (v.midStart != 0 && cycles == v.midStart) begin
        start = 1'b1;
        chall_in = ~v.chall;
      end else if (v.midStart != 0 && cycles == v.midStart + 1) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    checkOutput($sformatf("v%0d latency", idx), 32'(cycles), 32'(v.expLat));
    checkOutput($sformatf("v%0d response", idx), 32'(response), 32'(v.expResp));
    checkOutput($sformatf("v%0d err", idx), 32'(err), 32'(v.expErr));
    checkOutput($sformatf("v%0d busyAtDone", idx), 32'(busy), 32'd0);
    checkOutput($sformatf("v%0d challOut", idx), 32'(chall_out), 32'(v.chall));
    checkOutput($sformatf("v%0d loads", idx), 32'(loadCnt), 32'd1);
    checkOutput($sformatf("v%0d steps", idx), 32'(stepCnt), 32'd8);
    checkOutput($sformatf("v%0d clears", idx), 32'(clrCnt), 32'd8);
    checkOutput($sformatf("v%0d respStable", idx), 32'(unstable), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ro_en"}, 32'(ro_en), 32'd0);
    checkOutput({tag, " dp_clr"}, 32'(dp_clr), 32'd0);
    checkOutput({tag, " scr_load"}, 32'(scr_load), 32'd0);
    checkOutput({tag, " scr_step"}, 32'(scr_step), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " ready"}, 32'(ready), 32'd0);
    checkOutput({tag, " err"}, 32'(err), 32'd0);
    checkOutput({tag, " response"}, 32'(response), 32'd0);
    checkOutput({tag, " chall_out"}, 32'(chall_out), 32'd0);
  endtask

  initial begin
    int waitCnt;

    //         chall   arb  to  sim  winners hold mid  resp   err  latency
    vecs[0] = '{8'h3C, 3,   -1, -1,  8'hA5,  1'b0, 0,  8'hA5, 1'b0, 74};
    vecs[1] = '{8'h5A, 0,   -1, -1,  8'hFF,  1'b0, 0,  8'h00, 1'b1, 8242};
    vecs[2] = '{8'hC7, 1,   2,  5,   8'hFF,  1'b0, 0,  8'hFB, 1'b1, 2104};
    vecs[3] = '{8'h96, 1,   -1, 5,   8'hFF,  1'b0, 0,  8'hFF, 1'b0, 1081};
    vecs[4] = '{8'h11, 1,   -1, -1,  8'h00,  1'b1, 20, 8'hFF, 1'b0, 58};
    vecs[5] = '{8'h00, 2,   -1, -1,  8'h00,  1'b0, 0,  8'h00, 1'b0, 66};
    vecs[6] = '{8'hE1, 1,   -1, -1,  8'h81,  1'b0, 0,  8'h81, 1'b0, 58};

    rst = 1'b0;
    start = 1'b0;
    chall_in = 8'h00;
    arb_done = 1'b0;
    arb_winner = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) applyStimulus(i);

    // Reset in the middle of race index 3
    for (int i = 0; i < 8; i++) begin
      arbCycArr[i] = 6;
      winArr[i] = 1'b1;
    end
    holdMode = 1'b0;
    raceIdx = -1;
    @(negedge clk);
    chall_in = 8'h42;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitCnt = 0;
    while (!(raceIdx == 3 && roCnt == SETTLE + 2) && waitCnt < 2000) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("rstMid reachedRace", 32'(waitCnt < 2000), 32'd1);
    checkOutput("rstMid busyBefore", 32'(busy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkAllZero("rstMid");
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0);

    // Back-to-back: start held high across DONE
    for (int i = 0; i < 8; i++) begin
      arbCycArr[i] = 1;
      winArr[i] = (8'h3C >> i) & 1'b1;
    end
    raceIdx = -1;
    @(negedge clk);
    chall_in = 8'h77;
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("b2b firstBusy", 32'(busy), 32'd1);
    waitCnt = 0;
    while (!ready && waitCnt < 20000) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    checkOutput("b2b firstResp", 32'(response), 32'h3C);
    @(posedge clk);
    #1;
    checkOutput("b2b idleReady", 32'(ready), 32'd1);
    checkOutput("b2b idleBusy", 32'(busy), 32'd0);
    raceIdx = -1;
    for (int i = 0; i < 8; i++) winArr[i] = (8'hC3 >> i) & 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b secondReady", 32'(ready), 32'd0);
    checkOutput("b2b secondBusy", 32'(busy), 32'd1);
    checkOutput("b2b secondLoad", 32'(scr_load), 32'd1);
    checkOutput("b2b oldResp", 32'(response), 32'h3C);
    waitCnt = 0;
    while (!ready && waitCnt < 20000) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    checkOutput("b2b secondResp", 32'(response), 32'hC3);
    checkOutput("b2b secondErr", 32'(err), 32'd0);

    checkOutput("strobeExclusive", 32'(exclViol), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/ro_puf_controller.md
# ro_puf_controller

Sequencer for the serialized ring-oscillator PUF datapath (oscillator bank, challenge scrambler, two edge counters and the race arbiter). It accepts an 8-bit challenge and loads it into the scrambler. It then runs one race per response bit: clear the counters and arbiter, enable the oscillators, wait for the arbiter verdict, and step the scrambler. It assembles the winner bits into the response bus and raises `ready` when all bits are valid.

## Interface
Parameters:
- `RESP_W`, default 8, meaning: response width = number of races per challenge (≥1).
- `SETTLE_CYCLES`, default 4, meaning: cycles oscillators run before arbiter verdicts are accepted (≥1).
- `EVAL_CYCLES`, default 1024, meaning: watchdog limit per race (≥2).

Ports (clock and reset first):
- `clk`, input, 1, meaning: the one clock.
- `rst`, input, 1, meaning: reset, synchronous, active-low.
- `start`, input, 1, meaning: begin evaluation; sampled only in IDLE.
- `chall_in`, input, 8, meaning: challenge; captured on the accepted `start`.
- `arb_done`, input, 1, meaning: race arbiter has a verdict.
- `arb_winner`, input, 1, meaning: arbiter verdict bit; valid while `arb_done`=1.
- `ro_en`, output, 1, meaning: oscillator/counter enable.
- `dp_clr`, output, 1, meaning: active-high one-cycle clear of counters and arbiter.
- `scr_load`, output, 1, meaning: scrambler load strobe; load value is `chall_out`.
- `scr_step`, output, 1, meaning: scrambler advance strobe.
- `chall_out`, output, 8, meaning: latched challenge.
- `busy`, output, 1, meaning: evaluation in progress.
- `ready`, output, 1, meaning: `response` valid.
- `response`, output, RESP_W, meaning: assembled PUF response.
- `err`, output, 1, meaning: at least one race of the last evaluation timed out.

## Operation
- **States:** IDLE, LOAD, CLEAR, SETTLE, RACE, STEP, DONE.
- **IDLE:** `busy`=0.
  - `start`=1 → latch `chall_in` into `chall_out`, clear `ready`, `err`, the internal shift register and `bit_idx`; go to LOAD.
  - `start` is ignored in all other states.
- **LOAD:** `scr_load`=1 for exactly one cycle; go to CLEAR.
- **CLEAR:** `dp_clr`=1 and `ro_en`=0 for one cycle; go to SETTLE.
- **SETTLE:** `ro_en`=1 for SETTLE_CYCLES cycles. `arb_done` is ignored here. Then go to RACE with the watchdog at 0.
- **RACE:** `ro_en`=1; the watchdog increments every cycle.
  - `arb_done`=1 → write `arb_winner` into shift-register bit `bit_idx`; go to STEP.
  - Otherwise, if the watchdog reaches EVAL_CYCLES-1 → write 0 into bit `bit_idx`, set `err`; go to STEP.
  - `arb_done` wins over a simultaneous timeout, and `err` is not set.
- **STEP:** `ro_en`=0, `scr_step`=1 for one cycle.
  - `bit_idx`=RESP_W-1 → go to DONE.
  - Otherwise increment `bit_idx` → go to CLEAR.
- **DONE:** copy the shift register to `response`, set `ready`=1, `busy`=0; go to IDLE.
- **Output holding:**
  - `response` changes only on DONE entry, so it is stable throughout an evaluation.
  - `ready` stays 1 until the next `start` is accepted.
- **Bit order:** race i drives `response[i]`, LSB first.
- **`busy`:** 1 in LOAD through STEP.
- **Strobe exclusivity:** `scr_load`, `scr_step` and `dp_clr` are mutually exclusive. `ro_en` is never 1 in the same cycle as `dp_clr`.
- **Watchdog:** width is clog2(EVAL_CYCLES). It must not wrap.

## Timing
- All outputs are registered.
- **Reset values:** `rst`=0 at a clock edge forces IDLE and clears every register. On the following cycle:
  - `ro_en`, `dp_clr`, `scr_load`, `scr_step`, `busy`, `ready` and `err` are 0.
  - `response` and `chall_out` are 0.
- Reset mid-evaluation aborts it with no partial `response` update.
- `start` sampled high at edge k → `busy`=1 and `scr_load`=1 during cycle k+1.
- **Per-race length:** 1 (CLEAR) + SETTLE_CYCLES + r + 1 (STEP), where r ≥ 1 is the count of RACE cycles through the one that samples `arb_done`. A timed-out race has r = EVAL_CYCLES.
- **Total latency:** from the accepting edge to `ready`=1 is 2 + Σ(per-race length) cycles (LOAD + races + DONE).
- `ready` rises in the same cycle `busy` falls.
- A new `start` is accepted in the cycle after DONE at the earliest.

## Test plan
- **Basic evaluation:** Defaults; `chall_in`=0x3C; the model asserts `arb_done` on the 3rd RACE cycle of each race with winners 1,0,1,0,0,1,0,1 → `response`=0xA5, `err`=0, `ready`=1 exactly 74 cycles after the accepting edge. Also check 8 `scr_step` pulses, 1 `scr_load` with `chall_out`=0x3C, and 8 `dp_clr` pulses.
- **Timeout:** EVAL_CYCLES=16; `arb_done` held 0 → each RACE lasts 16 cycles, `response`=0x00, `err`=1.
- **Mixed/simultaneous:** Race 2 times out, race 5 has `arb_done` (winner 1) on the watchdog's final cycle, others have winner 1 → `response`=0xFB, `err`=1. Race 5 must not contribute to `err`.
- **Ignored inputs:** `arb_done`=1 with winner 0 held during SETTLE, then winner 1 from RACE onward → all bits 1. A `start` pulse with a new challenge mid-evaluation → ignored, `chall_out` unchanged.
- **Reset mid-race:** `rst`=0 for one cycle in race 4 → next cycle all outputs are 0, state is IDLE. A fresh `start` then completes normally.
- **Back-to-back:** `start` held high across DONE → second evaluation begins the cycle after `ready` rises. `ready` drops in the cycle after the accepting edge; `response` holds its old value until the new DONE.
